// File: rtl/imem_loader_if.sv
// Stream, status and fetch signals between the instruction-memory loader and
// its surroundings. Clock and reset stay plain ports on the loader itself.
interface imem_loader_if;
  // Load control and byte stream
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  // Load status
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] load_count;
  // Combinational fetch port
  logic [31:0] address;
  logic [31:0] Instr;

  // Driven by whoever feeds the loader and fetches instructions
  modport master (
    output start, byte_valid, byte_data, address,
    input  byte_ready, busy, cpu_hold, done, error, load_count, Instr
  );

  // The loader itself
  modport slave (
    input  start, byte_valid, byte_data, address,
    output byte_ready, busy, cpu_hold, done, error, load_count, Instr
  );
endinterface

// File: rtl/imem_loader.sv
// Writable instruction store filled from a byte stream. The stream carries a
// 16-bit little-endian word count N followed by 4N bytes, each word
// little-endian. The fetch port reads combinationally and stays usable during
// a load. The core is held off (cpu_hold) for as long as a load is in progress.
module imem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = 6
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    DONE   = 3'd4
  } state_e;

  state_e state, next_state;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [7:0]        len_lo;      // N[7:0], held until N[15:8] arrives
  logic [15:0]       n_words;     // word count of the current load
  logic [1:0]        bidx;        // byte position within the current word
  logic [ADDR_W-1:0] widx;        // next word to write
  logic [23:0]       shreg;       // bytes 0..2 of the current word, byte 0 lowest
  logic              error_q;
  logic [15:0]       load_count_q;

  logic        fire;              // a byte moves on this edge
  logic        wr_en;             // the 4th byte of a word moves on this edge
  logic [15:0] n_full;            // full length while in LEN_HI
  logic        last_word;         // the word being completed is word N-1

  assign bus.byte_ready = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
  assign fire           = bus.byte_valid && bus.byte_ready;
  assign n_full         = {bus.byte_data, len_lo};
  assign last_word      = (load_count_q + 16'd1) == n_words;

  assign bus.busy       = (state != IDLE);
  assign bus.cpu_hold   = bus.busy;
  assign bus.done       = (state == DONE);
  assign bus.error      = error_q;
  assign bus.load_count = load_count_q;

  // State register.
  // NOTE: registers take non-blocking assignments so every flop samples the
  // pre-edge values of its neighbours; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and write-enable decode.
  // NOTE: every output of this block gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    wr_en      = 1'b0;
    case (state)
      IDLE:   if (bus.start) next_state = LEN_LO;
      LEN_LO: if (fire) next_state = LEN_HI;
      LEN_HI: begin
        if (fire) begin
          if (n_full == 16'd0)              next_state = DONE;
          else if (n_full > 16'(DEPTH))     next_state = IDLE;
          else                              next_state = DATA;
        end
      end
      DATA: begin
        if (fire && bidx == 2'd3) begin
          wr_en = 1'b1;
          if (last_word) next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Length capture, byte assembly, counters and the sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_lo       <= '0;
      n_words      <= '0;
      bidx         <= '0;
      widx         <= '0;
      shreg        <= '0;
      error_q      <= 1'b0;
      load_count_q <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        error_q      <= 1'b0;
        load_count_q <= '0;
        bidx         <= '0;
        widx         <= '0;
      end
      if (state == LEN_LO && fire) len_lo <= bus.byte_data;
      if (state == LEN_HI && fire) begin
        n_words <= n_full;
        if (n_full > 16'(DEPTH)) error_q <= 1'b1;
      end
      if (state == DATA && fire) begin
        if (bidx == 2'd3) begin
          bidx         <= '0;
          widx         <= widx + 1'b1;
          load_count_q <= load_count_q + 16'd1;
        end else begin
          shreg <= {bus.byte_data, shreg[23:8]};
          bidx  <= bidx + 2'd1;
        end
      end
    end
  end

  // Word write on the 4th byte.
  // NOTE: the array has no reset on purpose; contents survive rst, and leaving it
  // out keeps the store mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[widx] <= {bus.byte_data, shreg};
  end

  // Fetch: word-indexed, upper address bits alias, byte offset ignored.
  assign bus.Instr = mem[bus.address[ADDR_W+1:2]];

  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, bus.address[31:ADDR_W+2], bus.address[1:0]};

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed loads for the documented scenarios, then
// random loads. A reference array models the store; done/error events are
// queued when a load is issued and matched by an independent monitor.
module tb_imem_loader;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_loader_if bus ();

  imem_loader #(.DATA_WIDTH(32), .DEPTH(DEPTH), .ADDR_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef enum logic {EV_DONE, EV_ERR} ev_kind_e;
  typedef struct packed {
    ev_kind_e    kind;
    logic [15:0] count;
  } ev_t;

  ev_t         exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] ref_mem   [DEPTH];
  bit          ref_known [DEPTH];
  logic [31:0] stim_words[DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse and every rising edge of error must match the
  // oldest queued expectation.
  initial begin
    bit prev_done = 1'b0;
    bit prev_err  = 1'b0;
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.done) begin
          check("done_single_cycle", {31'd0, prev_done}, 32'd0);
          if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            check("event_kind_done", {31'd0, e.kind}, {31'd0, EV_DONE});
            check("done_load_count", {16'd0, bus.load_count}, {16'd0, e.count});
          end
        end
        if (bus.error && !prev_err) begin
          if (exp_q.size() == 0) check("unexpected_error", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            check("event_kind_error", {31'd0, e.kind}, {31'd0, EV_ERR});
            check("error_load_count", {16'd0, bus.load_count}, {16'd0, e.count});
          end
        end
      end
      prev_done = bus.done;
      prev_err  = bus.error;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reads word idx through an aliased address with random upper and low bits.
  task automatic read_check(input int idx, input string name);
    logic [31:0] a;
    a = $urandom();
    a[7:2] = 6'(idx);
    bus.address = a;
    #1;
    if (ref_known[idx]) check(name, bus.Instr, ref_mem[idx]);
  endtask

  task automatic sweep();
    for (int i = 0; i < DEPTH; i++) read_check(i, "mem_sweep");
    @(negedge clk);
  endtask

  // Presents one byte (after gap idle cycles) and returns at the negedge after
  // the edge that accepted it.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited = 0;
    if (gap > 0) begin
      bus.byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (!bus.byte_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.byte_ready) begin
      check("byte_ready_timeout", 32'd0, 32'd1);
      bus.byte_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  // Start pulse with the first length byte already offered in the same cycle;
  // that byte must not move on the start edge.
  task automatic pulse_start(input logic [7:0] first);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_data  = first;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.byte_valid = 1'b0;
    check("start_busy", {31'd0, bus.busy}, 32'd1);
    check("start_byte_ready", {31'd0, bus.byte_ready}, 32'd1);
    check("start_clears_error", {31'd0, bus.error}, 32'd0);
    check("start_clears_count", {16'd0, bus.load_count}, 32'd0);
  endtask

  // Full load of n words from stim_words. poke pulses start mid-load.
  task automatic run_load(input int n, input int gap, input bit poke);
    logic [15:0] nl;
    logic [31:0] w;
    nl = 16'(n);
    if (n > DEPTH) exp_q.push_back('{EV_ERR, 16'd0});
    else           exp_q.push_back('{EV_DONE, nl});
    pulse_start(nl[7:0]);
    send_byte(nl[7:0], gap);
    send_byte(nl[15:8], gap);
    if (n > DEPTH) begin
      check("overlen_error", {31'd0, bus.error}, 32'd1);
      check("overlen_idle", {31'd0, bus.busy}, 32'd0);
      check("overlen_count", {16'd0, bus.load_count}, 32'd0);
      return;
    end
    if (n > 0) begin
      for (int wi = 0; wi < n; wi++) begin
        w = stim_words[wi];
        for (int b = 0; b < 4; b++) begin
          if (poke && wi == 1 && b == 0) begin
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            check("poke_busy", {31'd0, bus.busy}, 32'd1);
            check("poke_count", {16'd0, bus.load_count}, 32'd1);
            check("poke_ready", {31'd0, bus.byte_ready}, 32'd1);
          end
          if (b == 3) read_check(wi, "before_4th_byte");
          send_byte(w[8*b +: 8], gap);
        end
        ref_mem[wi]   = w;
        ref_known[wi] = 1'b1;
        read_check(wi, "after_4th_byte");
      end
    end
    check("done_after_last", {31'd0, bus.done}, 32'd1);
    @(negedge clk);
    check("idle_busy", {31'd0, bus.busy}, 32'd0);
    check("idle_cpu_hold", {31'd0, bus.cpu_hold}, 32'd0);
    check("idle_count", {16'd0, bus.load_count}, {16'd0, nl});
    check("idle_error", {31'd0, bus.error}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"}, {31'd0, bus.byte_ready}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_cpu_hold"}, {31'd0, bus.cpu_hold}, 32'd0);
    check({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_error"}, {31'd0, bus.error}, 32'd0);
    check({tag, "_load_count"}, {16'd0, bus.load_count}, 32'd0);
  endtask

  initial begin
    int n;
    int r;
    logic [31:0] w;
    bus.start      = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.address    = 32'h0;
    for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    #2 rst = 1'b0;
    @(negedge clk);

    // 1: two-word load
    stim_words[0] = 32'h00000013;
    stim_words[1] = 32'h00100093;
    run_load(2, 0, 1'b0);
    sweep();

    // 2: one word, byte_valid toggling
    stim_words[0] = 32'h00004033;
    run_load(1, 1, 1'b0);
    sweep();

    // 3: N = 65 rejected, store untouched
    run_load(65, 0, 1'b0);
    sweep();

    // 4: N = 0, done right after the length bytes
    run_load(0, 0, 1'b0);
    sweep();

    // 5: reset after 6 data bytes of an N=2 load
    pulse_start(8'h02);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    w = 32'hcafe0537;
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], 0);
    ref_mem[0] = w;
    w = 32'h12345678;
    send_byte(w[7:0], 0);
    send_byte(w[15:8], 0);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midload_reset");
    @(negedge clk);
    #2 rst = 1'b0;
    sweep();

    // 6: aliased fetch and start while busy
    stim_words[0] = 32'h00000113;
    stim_words[1] = 32'h00200193;
    stim_words[2] = 32'h00300213;
    stim_words[3] = 32'h00a00313;
    run_load(4, 0, 1'b1);
    bus.address = 32'h0000010C;
    #1 check("alias_fetch_10C", bus.Instr, 32'h00a00313);
    sweep();

    // Random loads
    for (int t = 0; t < 16; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      n = $urandom_range(65, 400);
      else if (r == 1) n = 0;
      else             n = $urandom_range(1, DEPTH);
      for (int i = 0; i < DEPTH; i++) stim_words[i] = $urandom();
      run_load(n, $urandom_range(0, 2), (n >= 2) && ($urandom_range(0, 1) == 1));
      sweep();
    end

    repeat (3) @(negedge clk);
    check("pending_events", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
